// File: rtl/freq_mult_datapath_if.sv
// Bus between the frequency-multiplier controller side (master) and its datapath (slave).
// Carries the raw input, the controller commands and the datapath results.
interface freq_mult_datapath_if #(
  parameter int CW = 16
);
  logic          sig_in;
  logic          countinit;
  logic          counten;
  logic          valid;
  logic          sip;
  logic [CW-1:0] period;
  logic          ovf;
  logic          fout;

  modport master (
    output sig_in, countinit, counten, valid,
    input  sip, period, ovf, fout
  );

  modport slave (
    input  sig_in, countinit, counten, valid,
    output sip, period, ovf, fout
  );
endinterface

// File: rtl/freq_mult_datapath.sv
// Frequency-multiplier datapath: input edge detection, period measurement under
// controller command, and square-wave synthesis at 2^MULT_LOG2 times the input rate.
module freq_mult_datapath #(
  parameter int CW        = 16,
  parameter int MULT_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  freq_mult_datapath_if.slave    bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          s3_q, s3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          fout_q, fout_d;
  logic          sip;
  logic [CW-1:0] half;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  // Truncated half-period of the output; never zero so the phase compare stays valid.
  function automatic logic [CW-1:0] half_of(input logic [CW-1:0] p);
    logic [CW-1:0] h;
    h = p >> (MULT_LOG2 + 1);
    return (h == '0) ? ONE : h;
  endfunction

  assign sip  = s2_q & ~s3_q;
  assign half = half_of(period_q);

  always_comb begin
    s1_d     = bus.sig_in;
    s2_d     = s1_q;
    s3_d     = s2_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    tcnt_d   = tcnt_q;
    fout_d   = fout_q;

    if (bus.countinit) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (bus.counten) begin
      // Either a saturating increment or a clipped period latch flags overflow.
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      if (sip) period_d = sat_inc(cnt_q);
      else     cnt_d    = sat_inc(cnt_q);
    end

    if (!bus.valid || period_q == '0) begin
      tcnt_d = '0;
      fout_d = 1'b0;
    end else if (tcnt_q == half - ONE) begin
      tcnt_d = '0;
      fout_d = ~fout_q;
    end else begin
      tcnt_d = tcnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      tcnt_q   <= '0;
      fout_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      tcnt_q   <= tcnt_d;
      fout_q   <= fout_d;
    end
  end

  assign bus.sip    = sip;
  assign bus.period = period_q;
  assign bus.ovf    = ovf_q;
  assign bus.fout   = fout_q;

endmodule

// File: tb/tb_freq_mult_datapath.sv
// Randomised bench for freq_mult_datapath: a CW=16 and a CW=8 instance share one stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_freq_mult_datapath;

  localparam int MULT_LOG2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0, countinit = 1'b0, counten = 1'b0, valid = 1'b0;

  always #5 clk = ~clk;

  freq_mult_datapath_if #(.CW(16)) bus0 ();
  freq_mult_datapath_if #(.CW(8))  bus1 ();

  assign bus0.sig_in = sig_in;  assign bus1.sig_in = sig_in;
  assign bus0.countinit = countinit;  assign bus1.countinit = countinit;
  assign bus0.counten = counten;  assign bus1.counten = counten;
  assign bus0.valid = valid;  assign bus1.valid = valid;

  freq_mult_datapath #(.CW(16), .MULT_LOG2(MULT_LOG2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  freq_mult_datapath #(.CW(8),  .MULT_LOG2(MULT_LOG2)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: sampled input history, elapsed count cycles, period, overflow, valid run length.
  bit h0 = 0, h1 = 0, h2 = 0, sip_m = 0;
  int e_m[2], per_m[2], k_m[2];
  bit ovf_m[2], fout_m[2];
  int maxv[2] = '{65535, 255};

  initial begin
    for (int i = 0; i < 2; i++) begin
      e_m[i] = 0; per_m[i] = 0; k_m[i] = 0; ovf_m[i] = 0; fout_m[i] = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int half_f(input int p);
    int h;
    h = p >> (MULT_LOG2 + 1);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) begin
      h0 = 0; h1 = 0; h2 = 0;
      for (int i = 0; i < 2; i++) begin
        e_m[i] = 0; per_m[i] = 0; k_m[i] = 0; ovf_m[i] = 0; fout_m[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!valid || per_m[i] == 0) begin
          k_m[i] = 0;
          fout_m[i] = 0;
        end else begin
          k_m[i]++;
          fout_m[i] = ((k_m[i] / half_f(per_m[i])) % 2) == 1;
        end
        if (countinit) begin
          e_m[i] = 0;
          ovf_m[i] = 0;
        end else if (counten) begin
          if (sip_m) begin
            per_m[i] = imin(e_m[i] + 1, maxv[i]);
            if (e_m[i] + 1 > maxv[i]) ovf_m[i] = 1;
          end else begin
            e_m[i]++;
            if (e_m[i] > maxv[i]) ovf_m[i] = 1;
          end
        end
      end
      h2 = h1; h1 = h0; h0 = sig_in;
    end
    sip_m = h1 & ~h2;
    #1;
    check("sip0", 32'(bus0.sip), 32'(sip_m));
    check("sip1", 32'(bus1.sip), 32'(sip_m));
    check("period0", 32'(bus0.period), per_m[0]);
    check("period1", 32'(bus1.period), per_m[1]);
    check("ovf0", 32'(bus0.ovf), 32'(ovf_m[0]));
    check("ovf1", 32'(bus1.ovf), 32'(ovf_m[1]));
    check("fout0", 32'(bus0.fout), 32'(fout_m[0]));
    check("fout1", 32'(bus1.fout), 32'(fout_m[1]));
    check("cnt0", 32'(dut0.cnt_q), imin(e_m[0], maxv[0]));
    check("cnt1", 32'(dut1.cnt_q), imin(e_m[1], maxv[1]));
  endtask

  // Controller behaviour: countinit on one sip, count to the next sip, then hold valid.
  task automatic run_meas(input int p, input int vcyc);
    int st = 0, ph = 0, guard = 0, kv = 0, first = -1, tog = 0, hs;
    bit prevf = 0, latch;
    hs = half_f(imin(p, maxv[0]));
    while (st != 3 && guard < 3 * p + vcyc + 20) begin
      sig_in = (ph < p / 2);
      ph = (ph + 1) % p;
      countinit = 0; counten = 0; valid = 0; latch = 0;
      case (st)
        0: if (sip_m) begin countinit = 1; st = 1; end
        1: begin counten = 1; if (sip_m) begin st = 2; latch = 1; end end
        default: valid = 1;
      endcase
      tick();
      guard++;
      if (countinit) check("ovf_clr1", 32'(bus1.ovf), 0);
      if (latch) begin
        check("meas_period0", 32'(bus0.period), imin(p, maxv[0]));
        check("meas_period1", 32'(bus1.period), imin(p, maxv[1]));
        check("meas_ovf1", 32'(bus1.ovf), (p > maxv[1]) ? 1 : 0);
      end
      if (valid) begin
        kv++;
        if (bus0.fout && first < 0) first = kv;
        if (bus0.fout != prevf) tog++;
        prevf = bus0.fout;
        if (kv == vcyc) st = 3;
      end
    end
    check("meas_done", st, 3);
    check("fout_first", first, hs);
    check("fout_toggles", tog, vcyc / hs);
    valid = 0;
    tick();
    check("fout_off", 32'(bus0.fout), 0);
  endtask

  initial begin
    int nsip, first_sip, t0, p;

    // Reset held three cycles while the input toggles.
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      sig_in = ~sig_in;
      tick();
      check("rst_sip", 32'(bus0.sip), 0);
      check("rst_fout", 32'(bus0.fout), 0);
      check("rst_ovf", 32'(bus0.ovf), 0);
      check("rst_period", 32'(bus0.period), 0);
    end
    rst = 0;
    sig_in = ~sig_in;
    tick();
    check("rel_sip", 32'(bus0.sip), 0);
    check("rel_period", 32'(bus0.period), 0);

    // Long high input gives exactly one pulse.
    sig_in = 0;
    for (int i = 0; i < 5; i++) tick();
    sig_in = 1;
    t0 = cyc + 1;
    nsip = 0;
    first_sip = -1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus0.sip) begin
        nsip++;
        if (first_sip < 0) first_sip = cyc;
      end
    end
    check("sip_count", nsip, 1);
    check("sip_lat", first_sip - t0, 1);

    // Directed measurements: nominal, clamped half, overflow, then ovf cleared by countinit.
    run_meas(64, 40);
    run_meas(10, 20);
    run_meas(300, 60);
    check("ovf_sticky1", 32'(bus1.ovf), 1);
    check("ovf_none0", 32'(bus0.ovf), 0);
    run_meas(64, 24);

    for (int r = 0; r < 5; r++) begin
      p = $urandom_range(4, 400);
      run_meas(p, 2 * half_f(p) + $urandom_range(0, 40));
    end

    // Free-running random commands; valid never overlaps counten so period is stable under valid.
    for (int i = 0; i < 400; i++) begin
      int rnd;
      rnd = $urandom_range(0, 7);
      countinit = (rnd == 0) || (rnd == 5 && ($urandom_range(0, 3) == 0));
      counten = (rnd >= 1 && rnd <= 5);
      valid = !counten && ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) sig_in = ~sig_in;
      tick();
    end

    // Simultaneous countinit and counten: clear wins.
    countinit = 0; counten = 1; valid = 0; sig_in = 0;
    for (int i = 0; i < 6; i++) tick();
    countinit = 1;
    tick();
    check("init_prio", 32'(dut0.cnt_q), 0);
    countinit = 0; counten = 0;

    // Reset in the middle of a count.
    run_meas(80, 20);
    countinit = 1;
    tick();
    countinit = 0; counten = 1;
    for (int i = 0; i < 30; i++) tick();
    check("cnt30", 32'(dut0.cnt_q), 30);
    rst = 1;
    tick();
    rst = 0; counten = 0;
    check("midrst_cnt", 32'(dut0.cnt_q), 0);
    check("midrst_period", 32'(bus0.period), 0);
    valid = 1;
    for (int i = 0; i < 30; i++) begin
      sig_in = (i % 6) < 3;
      tick();
      check("midrst_fout", 32'(bus0.fout), 0);
    end
    valid = 0;
    run_meas(100, 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
